// File: rtl/perceptron_pkg.sv
// Shared constants for the bit-serial perceptron layer: FSM encodings and score-width helper.
package perceptron_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_ARGMAX = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Score width large enough that WIDTH weights of WB bits can never overflow.
    function automatic int acc_w(input int wb, input int width);
        return wb + $clog2(width + 1);
    endfunction

endpackage

// File: rtl/perceptron_acc.sv
// Per-class score accumulator: adds the sign-extended weight whenever the current pixel is set.
module perceptron_acc
    import perceptron_pkg::*;
#(
    parameter int WB    = 4,
    parameter int ACC_W = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    en,
    input  logic                    pix,
    input  logic signed [WB-1:0]    weight,
    output logic signed [ACC_W-1:0] score
);

    logic signed [ACC_W-1:0] weight_ext;

    assign weight_ext = {{(ACC_W-WB){weight[WB-1]}}, weight};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score <= '0;
        end else if (clear) begin
            score <= '0;
        end else if (en && pix) begin
            score <= score + weight_ext;
        end
    end

endmodule

// File: rtl/perceptron_layer.sv
// Multi-class bit-serial perceptron layer: run-time loadable weights, one pixel per cycle
// into all class scores in parallel, then a sequential argmax over the class scores.
module perceptron_layer
    import perceptron_pkg::*;
#(
    parameter int WIDTH   = 25,
    parameter int CLASSES = 4,
    parameter int WB      = 4,
    parameter int ACC_W   = acc_w(WB, WIDTH),
    localparam int CW     = $clog2(CLASSES),
    localparam int PW     = $clog2(WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    w_we,
    input  logic [CW-1:0]           w_class,
    input  logic [PW-1:0]           w_idx,
    input  logic signed [WB-1:0]    w_data,
    output logic                    busy,
    output logic [CW-1:0]           out_class,
    output logic signed [ACC_W-1:0] out_score,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam logic [PW-1:0] PX_LAST = PW'(WIDTH - 1);
    localparam logic [CW-1:0] K_LAST  = CW'(CLASSES - 1);

    logic [1:0]              state;
    logic [WIDTH-1:0]        img;
    logic [PW-1:0]           px;
    logic [CW-1:0]           k;
    logic signed [ACC_W-1:0] best;
    logic [CW-1:0]           best_idx;
    logic signed [ACC_W-1:0] cand_best;
    logic [CW-1:0]           cand_idx;
    logic signed [ACC_W-1:0] score [CLASSES];
    logic signed [WB-1:0]    wram  [CLASSES][WIDTH];
    logic                    xfer;
    logic                    wr_en;

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign xfer      = in_valid && (state == ST_IDLE);
    assign wr_en     = w_we && (state == ST_IDLE) &&
                       (32'(w_idx) < WIDTH) && (32'(w_class) < CLASSES);

    // Weight RAM is deliberately not reset; a same-cycle write lands before ACCUM reads it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            wram[w_class][w_idx] <= w_data;
        end
    end

    for (genvar c = 0; c < CLASSES; c++) begin : g_acc
        perceptron_acc #(
            .WB    (WB),
            .ACC_W (ACC_W)
        ) u_acc (
            .clk    (clk),
            .rst_n  (rst_n),
            .clear  (xfer),
            .en     (state == ST_ACCUM),
            .pix    (img[px]),
            .weight (wram[c][px]),
            .score  (score[c])
        );
    end

    // Step k=0 seeds the running best with class 0; later steps replace only on strictly greater.
    always_comb begin
        cand_best = best;
        cand_idx  = best_idx;
        if (k == '0) begin
            cand_best = score[0];
            cand_idx  = '0;
        end else if (score[k] > best) begin
            cand_best = score[k];
            cand_idx  = k;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            img       <= '0;
            px        <= '0;
            k         <= '0;
            best      <= '0;
            best_idx  <= '0;
            out_class <= '0;
            out_score <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        img   <= in_data;
                        px    <= '0;
                        k     <= '0;
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (px == PX_LAST) begin
                        k     <= '0;
                        state <= ST_ARGMAX;
                    end else begin
                        px <= px + 1'b1;
                    end
                end
                ST_ARGMAX: begin
                    best     <= cand_best;
                    best_idx <= cand_idx;
                    if (k == K_LAST) begin
                        out_class <= cand_idx;
                        out_score <= cand_best;
                        state     <= ST_DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_layer.sv
// Directed, table-driven bench for perceptron_layer at default parameters.
module tb_perceptron_layer;

    logic               clk;
    logic               rst_n;
    logic [24:0]        in_data;
    logic               in_valid;
    logic               in_ready;
    logic               w_we;
    logic [1:0]         w_class;
    logic [4:0]         w_idx;
    logic signed [3:0]  w_data;
    logic               busy;
    logic [1:0]         out_class;
    logic signed [8:0]  out_score;
    logic               out_valid;
    logic               out_ready;

    int pass_cnt = 0;
    int total    = 0;

    perceptron_layer #(
        .WIDTH   (25),
        .CLASSES (4),
        .WB      (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .w_we      (w_we),
        .w_class   (w_class),
        .w_idx     (w_idx),
        .w_data    (w_data),
        .busy      (busy),
        .out_class (out_class),
        .out_score (out_score),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [24:0]       img;
        logic signed [3:0] w0;
        logic signed [3:0] w1;
        logic signed [3:0] w2;
        logic signed [3:0] w3;
        int                cls;
        int                score;
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mk(input logic [24:0] img, input int a, input int b,
                                input int c, input int d, input int cls, input int sc);
        vec_t v;
        v.img   = img;
        v.w0    = 4'(a);
        v.w1    = 4'(b);
        v.w2    = 4'(c);
        v.w3    = 4'(d);
        v.cls   = cls;
        v.score = sc;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic write_w(input int c, input int i, input int d);
        w_we    = 1'b1;
        w_class = 2'(c);
        w_idx   = 5'(i);
        w_data  = 4'(d);
        @(negedge clk);
        w_we = 1'b0;
    endtask

    task automatic load_all(input vec_t v);
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 25; i++) begin
                w_we    = 1'b1;
                w_class = 2'(c);
                w_idx   = 5'(i);
                w_data  = (c == 0) ? v.w0 : (c == 1) ? v.w1 : (c == 2) ? v.w2 : v.w3;
                @(negedge clk);
            end
        end
        w_we = 1'b0;
    endtask

    // Transfer one image, wait (bounded) for out_valid, compare, then hand-shake.
    task automatic run_image(input string nm, input logic [24:0] img, input int cls,
                             input int sc, input bit release_now);
        int cnt;
        cnt = -1;
        in_data  = img;
        in_valid = 1'b1;
        #1;
        chk({nm, " in_ready"}, int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                cnt = i;
                break;
            end
        end
        chk({nm, " latency"}, cnt, 29);
        chk({nm, " class"}, int'(out_class), cls);
        chk({nm, " score"}, int'(out_score), sc);
        if (release_now) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            chk({nm, " valid_drop"}, int'(out_valid), 0);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        w_we      = 1'b0;
        w_class   = '0;
        w_idx     = '0;
        w_data    = '0;
        out_ready = 1'b0;

        vecs[0] = mk(25'h1155151,  1, -1,  0,  0, 0,   10);
        vecs[1] = mk(25'h0454544,  1, -1,  0,  0, 0,    8);
        vecs[2] = mk(25'h0000000,  1, -1,  0,  0, 0,    0);
        vecs[3] = mk(25'h1FFFFFF,  7,  0,  0,  0, 0,  175);
        vecs[4] = mk(25'h1FFFFFF, -8, -8, -8, -8, 0, -200);
        vecs[5] = mk(25'h0000007, -3, -2, -5, -2, 1,   -6);
        vecs[6] = mk(25'h1000001, -1,  2,  3,  1, 2,    6);
        vecs[7] = mk(25'h00000FF,  0,  2, -1,  2, 1,   16);

        #2;
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst in_ready", int'(in_ready), 1);
        chk("rst out_class", int'(out_class), 0);
        chk("rst out_score", int'(out_score), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 8; t++) begin
            load_all(vecs[t]);
            run_image($sformatf("vec%0d", t), vecs[t].img, vecs[t].cls, vecs[t].score, 1'b1);
        end

        // C3 gains +1 on a set pixel: breaks the C1/C3 tie in favour of class 3.
        write_w(3, 0, 3);
        run_image("tiebreak", 25'h00000FF, 3, 17, 1'b1);

        // Backpressure: result held, second image refused, weight write ignored while busy.
        run_image("bp", 25'h00000FF, 3, 17, 1'b0);
        in_data  = 25'h1FFFFFF;
        in_valid = 1'b1;
        w_we     = 1'b1;
        w_class  = 2'd3;
        w_idx    = 5'd1;
        w_data   = -4'sd8;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp valid%0d", i), int'(out_valid), 1);
            chk($sformatf("bp in_ready%0d", i), int'(in_ready), 0);
            chk($sformatf("bp class%0d", i), int'(out_class), 3);
            chk($sformatf("bp score%0d", i), int'(out_score), 17);
        end
        in_valid = 1'b0;
        w_we     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("bp released", int'(in_ready), 1);
        @(negedge clk);
        run_image("bp rerun", 25'h00000FF, 3, 17, 1'b1);

        // Reset in the middle of accumulation.
        in_data  = 25'h00000FF;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort out_valid", int'(out_valid), 0);
        chk("abort in_ready", int'(in_ready), 1);
        chk("abort busy", int'(busy), 0);
        chk("abort out_score", int'(out_score), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_all(vecs[7]);
        write_w(3, 0, 3);
        run_image("post_abort", 25'h00000FF, 3, 17, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
